perf_counter_bank: RTL and testbench

Parametrised, memory-mapped bank of event counters that accumulates single-cycle increment pulses (branch, BTB hit, mispredict, and future events) from the CPU and exposes them over the 16-bit data-memory bus. It sits on the `mm_re`/`mm_we`/`addr`/`wdata`/`rdata` bus beside the other memory-mapped peripherals. It generalises the fixed three-pulse counting scheme to `NUM_CNT` channels of `CNT_W` bits, adding:
- coherent 32-bit reads through a 16-bit bus
- software preset and clear
- sticky overflow flags with an interrupt

---
 rtl/perf_cnt_pkg.sv | 14 +
 rtl/perf_cnt_slice.sv | 30 +++
 rtl/perf_counter_bank.sv | 80 ++++++++
 tb/tb_perf_counter_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/perf_cnt_pkg.sv
// perf_cnt_pkg: register offsets, CTRL bit positions and CTRL layout for perf_counter_bank
package perf_cnt_pkg;
    localparam logic [15:0] CTRL_OFS     = 16'd0;
    localparam logic [15:0] STATUS_OFS   = 16'd1;
    localparam logic [15:0] CNT_BASE_OFS = 16'd2;
    localparam int EN_BIT     = 0;
    localparam int CLR_BIT    = 1;
    localparam int IRQ_EN_BIT = 2;
    typedef struct packed {
        logic irq_en;
        logic clr;
        logic en;
    } ctrl_t;
endpackage

// File: rtl/perf_cnt_slice.sv
// perf_cnt_slice: one CNT_W-bit event counter with clear, 16-bit half presets and wrap detect
// ports: clk, rst_n (sync, active-low); clr zeroes the counter; inc counts one event;
//        lo_we/hi_we load wdata into bits [15:0] / [CNT_W-1:16]; value is the live count;
//        ovf pulses in the cycle an increment wraps all-ones to zero
module perf_cnt_slice #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             lo_we,
    input  logic             hi_we,
    input  logic [15:0]      wdata,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);
    // a preset or clear in the same cycle swallows the increment, so no wrap happens
    assign ovf = inc && !clr && !lo_we && !hi_we && &value;
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            value <= '0;
        end else if (lo_we || hi_we) begin
            if (lo_we) value[15:0] <= wdata;
            if (hi_we) value[CNT_W-1:16] <= wdata[CNT_W-17:0];
        end else if (inc) begin
            value <= value + CNT_W'(1);
        end
    end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: memory-mapped bank of NUM_CNT event counters with coherent reads and overflow irq
// ports: clk, rst_n (sync, active-low); inc[i] one event on channel i;
//        addr/wdata/mm_we/mm_re 16-bit bus; rdata/rdata_vld registered read return;
//        irq_ovf level interrupt from sticky overflow flags gated by CTRL.IRQ_EN
module perf_counter_bank
    import perf_cnt_pkg::*;
#(
    parameter int          NUM_CNT   = 3,
    parameter int          CNT_W     = 32,
    parameter logic [15:0] BASE_ADDR = 16'hC010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CNT-1:0] inc,
    input  logic [15:0]        addr,
    input  logic [15:0]        wdata,
    input  logic               mm_we,
    input  logic               mm_re,
    output logic [15:0]        rdata,
    output logic               rdata_vld,
    output logic               irq_ovf
);
    logic [15:0]        off;
    logic               hit, ctrl_we, status_we, clr;
    ctrl_t              ctrl;
    logic [NUM_CNT-1:0] status, ovf, lo_sel, hi_sel;
    logic [15:0]        shadow, rd_val, lo_hi;
    logic [CNT_W-1:0]   cnt [NUM_CNT];
    // addresses below BASE_ADDR wrap to large offsets and fall outside the map
    assign off       = addr - BASE_ADDR;
    assign hit       = off < 16'(CNT_BASE_OFS + 16'(2 * NUM_CNT));
    assign ctrl_we   = mm_we && off == CTRL_OFS;
    assign status_we = mm_we && off == STATUS_OFS;
    assign clr       = ctrl_we && wdata[CLR_BIT];
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        assign lo_sel[i] = off == 16'(CNT_BASE_OFS + 16'(2 * i));
        assign hi_sel[i] = off == 16'(CNT_BASE_OFS + 16'(2 * i + 1));
        perf_cnt_slice #(.CNT_W(CNT_W)) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (inc[i] && ctrl.en),
            .lo_we (mm_we && lo_sel[i]),
            .hi_we (mm_we && hi_sel[i]),
            .wdata (wdata),
            .value (cnt[i]),
            .ovf   (ovf[i])
        );
    end
    // read mux works on pre-write state, so a same-cycle write is not visible to the read
    always_comb begin
        rd_val = off == CTRL_OFS ? 16'(ctrl) : off == STATUS_OFS ? 16'(status) : 16'h0;
        lo_hi  = 16'h0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (lo_sel[i]) begin
                rd_val = cnt[i][15:0];
                lo_hi  = 16'(cnt[i][CNT_W-1:16]);
            end
            if (hi_sel[i]) rd_val = shadow;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl      <= '{irq_en: 1'b0, clr: 1'b0, en: 1'b1};
            status    <= '0;
            shadow    <= '0;
            rdata     <= '0;
            rdata_vld <= 1'b0;
            irq_ovf   <= 1'b0;
        end else begin
            if (ctrl_we) ctrl <= '{irq_en: wdata[IRQ_EN_BIT], clr: 1'b0, en: wdata[EN_BIT]};
            // a fresh overflow beats a same-cycle W1C; CLR beats both
            status <= clr ? '0 : (status & ~(status_we ? wdata[NUM_CNT-1:0] : '0)) | ovf;
            if (mm_re && |lo_sel) shadow <= lo_hi;
            rdata     <= (mm_re && hit) ? rd_val : 16'h0;
            rdata_vld <= mm_re && hit;
            irq_ovf   <= ctrl.irq_en && |status;
        end
    end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: scoreboard-driven bench for perf_counter_bank
module tb_perf_counter_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  inc = 3'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic        mm_we = 1'b0;
    logic        mm_re = 1'b0;
    logic [15:0] rdata;
    logic        rdata_vld;
    logic        irq_ovf;
    int          total = 0;
    int          pass = 0;
    typedef struct {
        string       nm;
        logic [15:0] d;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    localparam logic [15:0] CTRL = 16'hC010, STAT = 16'hC011;
    localparam logic [15:0] C0L = 16'hC012, C0H = 16'hC013, C1L = 16'hC014, C1H = 16'hC015;
    localparam logic [15:0] C2L = 16'hC016, C2H = 16'hC017, UND = 16'hC018;

    perf_counter_bank #(.NUM_CNT(3), .CNT_W(32), .BASE_ADDR(16'hC010)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .addr      (addr),
        .wdata     (wdata),
        .mm_we     (mm_we),
        .mm_re     (mm_re),
        .rdata     (rdata),
        .rdata_vld (rdata_vld),
        .irq_ovf   (irq_ovf)
    );

    always #5 clk = ~clk;

    // every read pushed in the previous cycle must come back now, in order
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0 || rdata_vld) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL spurious_vld: rdata_vld=%b rdata=%h, required no read return", rdata_vld, rdata);
            end else begin
                e = exp_q.pop_front();
                if (rdata_vld !== 1'b1 || rdata !== e.d)
                    $display("FAIL %s: rdata_vld=%b rdata=%h, required vld=1 rdata=%h", e.nm, rdata_vld, rdata, e.d);
                else
                    pass++;
            end
        end else if (rdata !== 16'h0) begin
            total++;
            $display("FAIL idle_rdata: rdata=%h, required 0000", rdata);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic bus(input logic re, input logic we, input logic [15:0] a, input logic [15:0] d, input logic [2:0] im);
        mm_re = re;
        mm_we = we;
        addr  = a;
        wdata = d;
        inc   = im;
        tick();
        mm_re = 1'b0;
        mm_we = 1'b0;
        inc   = 3'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus(1'b0, 1'b1, a, d, 3'b0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] x, input string nm);
        exp_q.push_back('{nm, x});
        bus(1'b1, 1'b0, a, 16'h0, 3'b0);
    endtask

    task automatic pulse(input logic [2:0] m, input int n);
        inc = m;
        repeat (n) tick();
        inc = 3'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        total += 3;
        if (irq_ovf !== 1'b0) $display("FAIL rst_irq: irq_ovf=%b, required 0", irq_ovf); else pass++;
        if (rdata_vld !== 1'b0) $display("FAIL rst_vld: rdata_vld=%b, required 0", rdata_vld); else pass++;
        if (rdata !== 16'h0) $display("FAIL rst_rdata: rdata=%h, required 0000", rdata); else pass++;
        rst_n = 1'b1;
        rd(CTRL, 16'h0001, "rst_ctrl");
        rd(STAT, 16'h0000, "rst_status");
        rd(C0L, 16'h0000, "rst_cnt0_lo");
    endtask

    task automatic test_count_enable;
        pulse(3'b010, 5);
        wr(CTRL, 16'h0000);
        pulse(3'b010, 3);
        wr(CTRL, 16'h0001);
        rd(C1L, 16'd5, "cnt1_lo");
        rd(C0L, 16'd0, "cnt0_lo_idle");
        rd(C2L, 16'd0, "cnt2_lo_idle");
        rd(C2H, 16'd0, "cnt2_hi_idle");
    endtask

    task automatic test_overflow;
        wr(C0H, 16'hFFFF);
        wr(C0L, 16'hFFFE);
        wr(CTRL, 16'h0005);
        pulse(3'b001, 1);
        pulse(3'b001, 1);
        total++;
        if (irq_ovf !== 1'b0) $display("FAIL ovf_irq_early: irq_ovf=%b, required 0", irq_ovf); else pass++;
        tick();
        total++;
        if (irq_ovf !== 1'b1) $display("FAIL ovf_irq_rise: irq_ovf=%b, required 1", irq_ovf); else pass++;
        rd(C0L, 16'h0000, "ovf_cnt0_lo");
        rd(C0H, 16'h0000, "ovf_cnt0_hi");
        rd(STAT, 16'h0001, "ovf_status");
        wr(STAT, 16'h0001);
        tick();
        total++;
        if (irq_ovf !== 1'b0) $display("FAIL ovf_irq_fall: irq_ovf=%b, required 0", irq_ovf); else pass++;
        rd(STAT, 16'h0000, "ovf_status_w1c");
    endtask

    task automatic test_coherent;
        wr(C2H, 16'h0001);
        wr(C2L, 16'hFFFF);
        rd(C2L, 16'hFFFF, "coh_lo");
        pulse(3'b100, 1);
        rd(C2H, 16'h0001, "coh_hi_shadow");
        rd(C2L, 16'h0000, "coh_lo_fresh");
        rd(C2H, 16'h0002, "coh_hi_fresh");
    endtask

    task automatic test_clr_same_cycle;
        wr(C1H, 16'hFFFF);
        wr(C1L, 16'hFFFF);
        pulse(3'b010, 1);
        rd(STAT, 16'h0002, "clr_pre_status");
        wr(C0H, 16'hFFFF);
        wr(C0L, 16'hFFFF);
        bus(1'b0, 1'b1, CTRL, 16'h0007, 3'b001);
        tick();
        total++;
        if (irq_ovf !== 1'b0) $display("FAIL clr_irq: irq_ovf=%b, required 0", irq_ovf); else pass++;
        rd(C0L, 16'h0000, "clr_cnt0_lo");
        rd(C0H, 16'h0000, "clr_cnt0_hi");
        rd(C1L, 16'h0000, "clr_cnt1_lo");
        rd(C2L, 16'h0000, "clr_cnt2_lo");
        rd(STAT, 16'h0000, "clr_status");
        rd(CTRL, 16'h0005, "clr_ctrl_readback");
    endtask

    task automatic test_undecoded;
        bus(1'b1, 1'b0, UND, 16'h0, 3'b0);
        total += 2;
        if (rdata_vld !== 1'b0) $display("FAIL und_vld: rdata_vld=%b, required 0", rdata_vld); else pass++;
        if (rdata !== 16'h0) $display("FAIL und_rdata: rdata=%h, required 0000", rdata); else pass++;
        wr(UND, 16'hFFFF);
        rd(CTRL, 16'h0005, "und_ctrl");
        rd(STAT, 16'h0000, "und_status");
        rd(C2L, 16'h0000, "und_cnt2_lo");
        rd(C2H, 16'h0000, "und_cnt2_hi");
    endtask

    task automatic test_back_to_back;
        wr(C1H, 16'h1234);
        wr(C1L, 16'hABCD);
        mm_re = 1'b1;
        addr = C1L; exp_q.push_back('{"b2b_lo", 16'hABCD}); tick();
        addr = C1H; exp_q.push_back('{"b2b_hi", 16'h1234}); tick();
        addr = CTRL; exp_q.push_back('{"b2b_ctrl", 16'h0005}); tick();
        addr = C1L; mm_we = 1'b1; wdata = 16'h5555;
        exp_q.push_back('{"rw_pre_value", 16'hABCD}); tick();
        mm_we = 1'b0; exp_q.push_back('{"rw_post_value", 16'h5555}); tick();
        mm_re = 1'b0;
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        bus(1'b1, 1'b1, CTRL, 16'h0006, 3'b111);
        total += 2;
        if (rdata_vld !== 1'b0) $display("FAIL mid_rst_vld: rdata_vld=%b, required 0", rdata_vld); else pass++;
        if (irq_ovf !== 1'b0) $display("FAIL mid_rst_irq: irq_ovf=%b, required 0", irq_ovf); else pass++;
        rst_n = 1'b1;
        rd(C1H, 16'h0000, "mid_rst_shadow");
        rd(CTRL, 16'h0001, "mid_rst_ctrl");
        rd(C1L, 16'h0000, "mid_rst_cnt1_lo");
        rd(STAT, 16'h0000, "mid_rst_status");
    endtask

    initial begin
        test_reset();
        test_count_enable();
        test_overflow();
        test_coherent();
        test_clr_same_cycle();
        test_undecoded();
        test_back_to_back();
        test_reset_mid();
        tick();
        tick();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
